// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet TX scheduler and the RMII frame transmitter:
// scheduler states, inter-frame-gap arithmetic and the payload field layout.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        SEND,
        GAP
    } sched_state_t;

    localparam int RMII_BITS_PER_CLK = 2;
    localparam int IFG_BITS          = 96;
    localparam int IFG_CYCLES_DEF    = IFG_BITS / RMII_BITS_PER_CLK;

    // Payload packing agreed with the frame transmitter (40 bits total).
    localparam int PLAYER_X_OFF  = 0;
    localparam int PLAYER_X_W    = 12;
    localparam int PLAYER_Y_OFF  = 12;
    localparam int PLAYER_Y_W    = 12;
    localparam int DIRECTION_OFF = 24;
    localparam int DIRECTION_W   = 4;
    localparam int GAME_STAT_OFF = 28;
    localparam int GAME_STAT_W   = 12;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/eth_tx_scheduler_if.sv
// Request-side and transmitter-side signals of the TX scheduler in one bundle.
// The master modport is the scheduler; the slave modport is its environment.
interface eth_tx_scheduler_if #(
    parameter int NUM_REQ   = 2,
    parameter int PAYLOAD_W = 40
);
    localparam int SRC_W = eth_pkg::idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*PAYLOAD_W-1:0] req_payload;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         tx_start;
    logic [PAYLOAD_W-1:0]         tx_payload;
    logic [SRC_W-1:0]             tx_src;
    logic                         tx_busy;
    logic                         sched_idle;
    logic                         timeout_err;
    logic [15:0]                  frames_sent;

    modport master (
        input  req_valid, req_payload, tx_busy,
        output req_ready, tx_start, tx_payload, tx_src, sched_idle, timeout_err, frames_sent
    );

    modport slave (
        output req_valid, req_payload, tx_busy,
        input  req_ready, tx_start, tx_payload, tx_src, sched_idle, timeout_err, frames_sent
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester found after 'last'
// (wrapping modulo NUM_REQ) wins; outputs a one-hot grant and its index.
module rr_arbiter
    import eth_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index
);

    int         cand;
    logic [IDX_W-1:0] sel;
    logic       found;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = 0;
        sel   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            sel = cand[IDX_W-1:0];
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                index      = sel;
            end
        end
    end

endmodule

// File: rtl/eth_tx_scheduler.sv
// Shares one RMII frame transmitter between several packet sources: round-robin
// grant, one-cycle launch, busy/timeout tracking and inter-frame gap enforcement.
module eth_tx_scheduler
    import eth_pkg::*;
#(
    parameter int NUM_REQ          = 2,
    parameter int PAYLOAD_W        = 40,
    parameter int IFG_CYCLES       = IFG_CYCLES_DEF,
    parameter int START_WAIT       = 16,
    parameter int MAX_FRAME_CYCLES = 2048
) (
    input  logic              eth_clk,
    input  logic              eth_rst_n,
    eth_tx_scheduler_if.master bus
);

    localparam int SRC_W = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_FRAME_CYCLES);

    sched_state_t         state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SRC_W-1:0]     last_q, last_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic [SRC_W-1:0]     src_q, src_d;
    logic                 timeout_q, timeout_d;
    logic [15:0]          frames_q, frames_d;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [SRC_W-1:0]     arb_index;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (SRC_W)
    ) u_arb (
        .req   (bus.req_valid),
        .last  (last_q),
        .grant (arb_grant),
        .index (arb_index)
    );

    always_ff @(posedge eth_clk) begin
        if (!eth_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= SRC_W'(NUM_REQ - 1);
            payload_q <= '0;
            src_q     <= '0;
            timeout_q <= 1'b0;
            frames_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            payload_q <= payload_d;
            src_q     <= src_d;
            timeout_q <= timeout_d;
            frames_q  <= frames_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        payload_d = payload_q;
        src_d     = src_q;
        timeout_d = timeout_q;
        frames_d  = frames_q;
        req_ready = '0;
        tx_start  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    req_ready = arb_grant;
                    payload_d = bus.req_payload[arb_index*PAYLOAD_W +: PAYLOAD_W];
                    src_d     = arb_index;
                    last_d    = arb_index;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_start = 1'b1;
                cnt_d    = '0;
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    cnt_d   = '0;
                    state_d = SEND;
                end else if (cnt_q == CNT_W'(START_WAIT - 1)) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SEND: begin
                if (!bus.tx_busy) begin
                    frames_d = frames_q + 16'd1;
                    cnt_d    = '0;
                    state_d  = GAP;
                end else if (cnt_q == CNT_W'(MAX_FRAME_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                // A late or stuck busy freezes the gap count, stretching the gap.
                if (!bus.tx_busy) begin
                    if (cnt_q == CNT_W'(IFG_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req_ready   = req_ready;
    assign bus.tx_start    = tx_start;
    assign bus.tx_payload  = payload_q;
    assign bus.tx_src      = src_q;
    assign bus.sched_idle  = (state_q == IDLE);
    assign bus.timeout_err = timeout_q;
    assign bus.frames_sent = frames_q;

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Directed bench for eth_tx_scheduler: grant/launch timing, gap length, fairness,
// start and frame timeouts, frame counter wrap and reset during a frame.
module tb_eth_tx_scheduler;

    logic eth_clk;
    logic eth_rst_n;

    int checks;
    int failures;
    int rdy0;
    int rdy1;
    int gap;
    int n;
    logic [39:0] p0;
    logic [39:0] p1;

    eth_tx_scheduler_if #(.NUM_REQ(2), .PAYLOAD_W(40)) bus ();

    eth_tx_scheduler #(
        .NUM_REQ          (2),
        .PAYLOAD_W        (40),
        .IFG_CYCLES       (48),
        .START_WAIT       (16),
        .MAX_FRAME_CYCLES (2048)
    ) dut (
        .eth_clk   (eth_clk),
        .eth_rst_n (eth_rst_n),
        .bus       (bus)
    );

    initial eth_clk = 1'b0;
    always #5 eth_clk = ~eth_clk;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge eth_clk);
    endtask

    task automatic count_ready();
        rdy0 += int'(bus.req_ready[0]);
        rdy1 += int'(bus.req_ready[1]);
    endtask

    task automatic do_reset();
        eth_rst_n = 1'b0;
        tick();
        tick();
        eth_rst_n = 1'b1;
    endtask

    // Called at the LAUNCH-cycle negedge; models the transmitter and returns the
    // number of cycles from busy falling to the scheduler reporting idle.
    task automatic drive_busy(input int start_delay, input int busy_len, output int gap_len);
        repeat (start_delay) begin
            tick();
            count_ready();
        end
        bus.tx_busy = 1'b1;
        repeat (busy_len) begin
            tick();
            count_ready();
        end
        bus.tx_busy = 1'b0;
        gap_len = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            gap_len++;
            if (bus.sched_idle) break;
            count_ready();
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        checks          = 0;
        failures        = 0;
        rdy0            = 0;
        rdy1            = 0;
        eth_rst_n       = 1'b0;
        bus.req_valid   = '0;
        bus.req_payload = '0;
        bus.tx_busy     = 1'b0;

        // Reset values
        tick();
        tick();
        check_output("rst_idle", bus.sched_idle, 1'b1);
        check_output("rst_ready", bus.req_ready, 2'b00);
        check_output("rst_start", bus.tx_start, 1'b0);
        check_output("rst_payload", bus.tx_payload, 40'h0);
        check_output("rst_src", bus.tx_src, 1'b0);
        check_output("rst_timeout", bus.timeout_err, 1'b0);
        check_output("rst_frames", bus.frames_sent, 16'd0);
        eth_rst_n = 1'b1;

        // Single frame from requester 0, 400-cycle busy
        bus.req_payload[39:0] = 40'h1234567890;
        bus.req_valid = 2'b01;
        #1;
        check_output("f1_grant", bus.req_ready, 2'b01);
        check_output("f1_no_start_yet", bus.tx_start, 1'b0);
        tick();
        bus.req_valid = 2'b00;
        check_output("f1_start", bus.tx_start, 1'b1);
        check_output("f1_payload", bus.tx_payload, 40'h1234567890);
        check_output("f1_src", bus.tx_src, 1'b0);
        check_output("f1_ready_low", bus.req_ready, 2'b00);
        tick();
        check_output("f1_start_oneshot", bus.tx_start, 1'b0);
        drive_busy(0, 400, gap);
        check_output("f1_gap", gap, 49);
        check_output("f1_frames", bus.frames_sent, 16'd1);
        check_output("f1_payload_held", bus.tx_payload, 40'h1234567890);

        // Fairness: both requesters held valid for four frames
        do_reset();
        rdy0 = 0;
        rdy1 = 0;
        p0 = 40'hA0A0A0A0A0;
        p1 = 40'h5B5B5B5B5B;
        bus.req_payload = {p1, p0};
        bus.req_valid = 2'b11;
        #1;
        for (int f = 0; f < 4; f++) begin
            check_output("rr_grant", bus.req_ready, (f % 2 == 1) ? 2'b10 : 2'b01);
            count_ready();
            tick();
            check_output("rr_src", bus.tx_src, (f % 2 == 1) ? 1'b1 : 1'b0);
            check_output("rr_payload", bus.tx_payload, (f % 2 == 1) ? p1 : p0);
            drive_busy(1, 20, gap);
            check_output("rr_gap", gap, 49);
        end
        bus.req_valid = 2'b00;
        check_output("rr_ready0_pulses", rdy0, 2);
        check_output("rr_ready1_pulses", rdy1, 2);
        check_output("rr_frames", bus.frames_sent, 16'd4);

        // Transmitter never raises busy
        bus.req_valid = 2'b01;
        #1;
        check_output("to_grant", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        check_output("to_start", bus.tx_start, 1'b1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (bus.timeout_err) break;
        end
        check_output("to_start_wait", n, 17);
        check_output("to_frames_unchanged", bus.frames_sent, 16'd4);
        check_output("to_in_gap", bus.sched_idle, 1'b0);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            n++;
            if (bus.sched_idle) break;
        end
        check_output("to_gap", n, 48);
        bus.req_valid = 2'b10;
        #1;
        check_output("to_next_grant", bus.req_ready, 2'b10);
        tick();
        bus.req_valid = 2'b00;
        check_output("to_next_src", bus.tx_src, 1'b1);
        drive_busy(1, 30, gap);
        check_output("to_next_gap", gap, 49);
        check_output("to_next_frames", bus.frames_sent, 16'd5);
        check_output("to_sticky", bus.timeout_err, 1'b1);

        // Busy stuck high
        do_reset();
        bus.req_valid = 2'b01;
        #1;
        check_output("stuck_grant", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        tick();
        bus.tx_busy = 1'b1;
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            n++;
            if (bus.timeout_err) break;
        end
        check_output("stuck_send_timeout", n, 2049);
        check_output("stuck_frames", bus.frames_sent, 16'd0);
        repeat (100) tick();
        check_output("stuck_gap_holds", bus.sched_idle, 1'b0);
        bus.tx_busy = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            n++;
            if (bus.sched_idle) break;
        end
        check_output("stuck_gap", n, 48);

        // Frame counter wrap
        force dut.frames_q = 16'hFFFF;
        tick();
        tick();
        release dut.frames_q;
        check_output("wrap_preset", bus.frames_sent, 16'hFFFF);
        bus.req_valid = 2'b10;
        #1;
        check_output("wrap_grant", bus.req_ready, 2'b10);
        tick();
        bus.req_valid = 2'b00;
        drive_busy(1, 10, gap);
        check_output("wrap_frames", bus.frames_sent, 16'd0);

        // Reset in the middle of SEND
        bus.req_payload[79:40] = 40'hDEADBEEF01;
        bus.req_valid = 2'b10;
        #1;
        tick();
        bus.req_valid = 2'b00;
        check_output("mid_payload", bus.tx_payload, 40'hDEADBEEF01);
        tick();
        bus.tx_busy = 1'b1;
        repeat (5) tick();
        check_output("mid_sending", bus.sched_idle, 1'b0);
        eth_rst_n = 1'b0;
        tick();
        check_output("mid_rst_idle", bus.sched_idle, 1'b1);
        check_output("mid_rst_start", bus.tx_start, 1'b0);
        check_output("mid_rst_ready", bus.req_ready, 2'b00);
        check_output("mid_rst_payload", bus.tx_payload, 40'h0);
        check_output("mid_rst_src", bus.tx_src, 1'b0);
        check_output("mid_rst_timeout", bus.timeout_err, 1'b0);
        check_output("mid_rst_frames", bus.frames_sent, 16'd0);
        eth_rst_n = 1'b1;
        bus.tx_busy = 1'b0;
        bus.req_valid = 2'b11;
        #1;
        check_output("mid_first_grant", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        check_output("mid_first_src", bus.tx_src, 1'b0);
        check_output("mid_first_start", bus.tx_start, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
